// File: rtl/keyboard_fifo.sv
// Scan-code FIFO between the PS/2 receiver and the CPU poll port.
// Define KBD_FIFO_DROP_OLDEST_EN to make a push into a full FIFO drop the oldest entry.
module keyboard_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH_LOG2  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  we,
  input  logic                  poll,
  input  logic                  clear,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AFULL_C = (DEPTH_LOG2+1)'(AFULL_LEVEL);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  logic push;
  logic pop;
  logic lost;
  logic drop;

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= AFULL_C);

  assign rd_valid = poll && !empty;
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  assign pop  = rd_valid;
  assign lost = we && full && !poll;

`ifdef KBD_FIFO_DROP_OLDEST_EN
  // Full FIFO: the write lands on the head slot and the head moves past it.
  assign push = we;
  assign drop = lost;
`else
  assign push = we && !lost;
  assign drop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop || drop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop && !full) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (lost) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
